// File: rtl/imm_gen_pkg.sv
// Shared decode definitions for the RV32I immediate path: format-select codes and datapath width.
package imm_gen_pkg;

   localparam int XLEN = 32;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_U = 2'b11;

   // Replicate instr[31] above a field whose MSB sits at bit position msb.
   function automatic logic [XLEN-1:0] sext_from(input logic [XLEN-1:0] field, input int msb);
      logic [XLEN-1:0] res;
      for (int i = 0; i < XLEN; i++) begin
         res[i] = (i > msb) ? field[msb] : field[i];
      end
      return res;
   endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational RV32I immediate extraction and sign extension, selected by a 2-bit format code.
module imm_extract
   import imm_gen_pkg::*;
(
   input  logic [XLEN-1:0] instr,
   input  logic [1:0]      sel,
   output logic [XLEN-1:0] imm
);

   // Opcode bits never steer the format; sel alone decides.
   logic unused_opcode;
   assign unused_opcode = ^instr[6:0];

   always_comb begin
      // NOTE: imm gets a default before the case so no path leaves it unassigned (no latch).
      imm = '0;
      unique case (sel)
         IMM_I: imm = sext_from({20'b0, instr[31:20]}, 11);
         IMM_S: imm = sext_from({20'b0, instr[31:25], instr[11:7]}, 11);
         IMM_B: imm = sext_from({19'b0, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}, 12);
         IMM_U: imm = {instr[31:12], 12'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/imm_gen.sv
// Registered immediate generator: imm_extract followed by a result register and valid flop.
module imm_gen
   import imm_gen_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] inInstr,
   input  logic [1:0]      sl,
   input  logic            in_valid,
   output logic [XLEN-1:0] outIMM,
   output logic            out_valid
);

   logic [XLEN-1:0] imm;

   imm_extract u_extract (
      .instr (inInstr),
      .sel   (sl),
      .imm   (imm)
   );

   // Result register only loads on valid, so garbage on sl while idle never reaches outIMM.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (rst) begin
         outIMM    <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) outIMM <= imm;
      end
   end

endmodule

// File: tb/tb_imm_gen.sv
// Self-checking bench for imm_gen: directed vector table plus reset, back-to-back and hold sequences.
module tb_imm_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inInstr;
   logic [1:0]  sl;
   logic        in_valid;
   logic [31:0] outIMM;
   logic        out_valid;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [1:0]  sl;
      logic [31:0] instr;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[12];

   imm_gen dut (
      .clk       (clk),
      .rst       (rst),
      .inInstr   (inInstr),
      .sl        (sl),
      .in_valid  (in_valid),
      .outIMM    (outIMM),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic [1:0] s, input logic [31:0] i);
      in_valid = v;
      sl       = s;
      inInstr  = i;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{2'b00, 32'hFFF0_0000, 32'hFFFF_FFFF};
      vecs[1]  = '{2'b00, 32'h7FF0_0000, 32'h0000_07FF};
      vecs[2]  = '{2'b00, 32'h0010_0093, 32'h0000_0001};
      vecs[3]  = '{2'b00, 32'h8000_0000, 32'hFFFF_F800};
      vecs[4]  = '{2'b01, 32'hFE00_0F80, 32'hFFFF_FFFF};
      vecs[5]  = '{2'b01, 32'h0000_0080, 32'h0000_0001};
      vecs[6]  = '{2'b01, 32'h0011_2623, 32'h0000_000C};
      vecs[7]  = '{2'b10, 32'h7E00_0F80, 32'h0000_0FFE};
      vecs[8]  = '{2'b10, 32'h8000_0000, 32'hFFFF_F000};
      vecs[9]  = '{2'b10, 32'hFE00_0EE3, 32'hFFFF_FFFC};
      vecs[10] = '{2'b11, 32'hFFFF_F037, 32'hFFFF_F000};
      vecs[11] = '{2'b11, 32'h1234_5678, 32'h1234_5000};

      // Reset held two cycles with a live request that must be ignored.
      rst      = 1'b1;
      in_valid = 1'b1;
      sl       = 2'b00;
      inInstr  = 32'hFFF0_0000;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("reset_imm_%0d", c), outIMM, 32'h0);
         check($sformatf("reset_valid_%0d", c), {31'b0, out_valid}, 32'h0);
      end
      rst = 1'b0;

      // Back-to-back table: each result is visible one edge after its request.
      for (int k = 0; k < 12; k++) begin
         step(1'b1, vecs[k].sl, vecs[k].instr);
         check($sformatf("vec%0d_imm", k), outIMM, vecs[k].exp);
         check($sformatf("vec%0d_valid", k), {31'b0, out_valid}, 32'h1);
      end

      // Explicit I, S, B, U stream, then idle with an undefined select.
      step(1'b1, 2'b00, 32'h7FF0_0000);
      check("seq_i", outIMM, 32'h0000_07FF);
      step(1'b1, 2'b01, 32'h0000_0080);
      check("seq_s", outIMM, 32'h0000_0001);
      step(1'b1, 2'b10, 32'h8000_0000);
      check("seq_b", outIMM, 32'hFFFF_F000);
      step(1'b1, 2'b11, 32'h1234_5678);
      check("seq_u", outIMM, 32'h1234_5000);
      check("seq_u_valid", {31'b0, out_valid}, 32'h1);
      for (int c = 0; c < 2; c++) begin
         step(1'b0, 2'bxx, 32'hDEAD_BEEF);
         check($sformatf("hold_imm_%0d", c), outIMM, 32'h1234_5000);
         check($sformatf("hold_valid_%0d", c), {31'b0, out_valid}, 32'h0);
      end

      // Request coincident with reset is discarded; first request after release goes through.
      step(1'b1, 2'b00, 32'h7FF0_0000);
      check("pre_rst_imm", outIMM, 32'h0000_07FF);
      rst = 1'b1;
      step(1'b1, 2'b00, 32'hFFF0_0000);
      check("mid_rst_imm", outIMM, 32'h0);
      check("mid_rst_valid", {31'b0, out_valid}, 32'h0);
      rst = 1'b0;
      step(1'b1, 2'b10, 32'h7E00_0F80);
      check("post_rst_imm", outIMM, 32'h0000_0FFE);
      check("post_rst_valid", {31'b0, out_valid}, 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
